// File: rtl/instruction_fetch_if.sv
// ============================================================================
// instruction_fetch_if : instruction memory request/response bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
  logic [31:0] addr;
  logic        read;
  logic [31:0] readdata;
  logic        busywait;

  modport master (
    output addr,
    output read,
    input  readdata,
    input  busywait
  );

  modport slave (
    input  addr,
    input  read,
    output readdata,
    output busywait
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : PC register, imem fetch FSM and IF/ID pipeline register
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  stall,
  input  wire logic                  ex_branch_taken,
  input  wire logic [31:0]           ex_branch_target,
  instruction_fetch_if.master        imem,
  output logic      [31:0]           if_pc,
  output logic      [31:0]           if_instruction,
  output logic      [31:0]           if_pc_plus4,
  output logic                       if_valid,
  output logic                       if_busywait
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_buffer, w_buffer;
  logic [31:0] r_if_pc, w_if_pc;
  logic [31:0] r_if_instr, w_if_instr;
  logic [31:0] r_if_pc_plus4, w_if_pc_plus4;
  logic        r_if_valid, w_if_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = {ex_branch_target[31:2], 2'b00};

  assign imem.addr      = r_pc;
  assign imem.read      = (r_state == S_FETCH) && !rst;
  assign if_pc          = r_if_pc;
  assign if_instruction = r_if_instr;
  assign if_pc_plus4    = r_if_pc_plus4;
  assign if_valid       = r_if_valid;

  always_comb begin
    w_state       = r_state;
    w_pc          = r_pc;
    w_buffer      = r_buffer;
    w_if_pc       = r_if_pc;
    w_if_instr    = r_if_instr;
    w_if_pc_plus4 = r_if_pc_plus4;
    w_if_valid    = r_if_valid;
    if_busywait   = 1'b0;

    case (r_state)
      S_FETCH: begin
        if_busywait = imem.busywait;
        if (ex_branch_taken) begin
          w_pc          = w_target;
          w_if_pc       = 32'd0;
          w_if_instr    = NOP_INSTR;
          w_if_pc_plus4 = 32'd0;
          w_if_valid    = 1'b0;
          w_buffer      = 32'd0;
          // An outstanding access must drain before the new address is issued
          w_state       = imem.busywait ? S_DISCARD : S_FETCH;
        end else if (!imem.busywait) begin
          if (stall) begin
            w_buffer = imem.readdata;
            w_state  = S_HOLD;
          end else begin
            w_if_pc       = r_pc;
            w_if_instr    = imem.readdata;
            w_if_pc_plus4 = w_pc_plus4;
            w_if_valid    = 1'b1;
            w_pc          = w_pc_plus4;
          end
        end
      end

      S_HOLD: begin
        if (ex_branch_taken) begin
          w_pc          = w_target;
          w_if_pc       = 32'd0;
          w_if_instr    = NOP_INSTR;
          w_if_pc_plus4 = 32'd0;
          w_if_valid    = 1'b0;
          w_buffer      = 32'd0;
          w_state       = S_FETCH;
        end else if (!stall) begin
          w_if_pc       = r_pc;
          w_if_instr    = r_buffer;
          w_if_pc_plus4 = w_pc_plus4;
          w_if_valid    = 1'b1;
          w_pc          = w_pc_plus4;
          w_state       = S_FETCH;
        end
      end

      S_DISCARD: begin
        if_busywait = 1'b1;
        if (ex_branch_taken) begin
          w_pc = w_target;
        end
        if (!imem.busywait) begin
          w_state = S_FETCH;
        end
      end

      default: begin
        w_state = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_VECTOR;
      r_buffer      <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_instr    <= NOP_INSTR;
      r_if_pc_plus4 <= 32'd0;
      r_if_valid    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_pc          <= w_pc;
      r_buffer      <= w_buffer;
      r_if_pc       <= w_if_pc;
      r_if_instr    <= w_if_instr;
      r_if_pc_plus4 <= w_if_pc_plus4;
      r_if_valid    <= w_if_valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: zero-wait fetch, busywait, stall/hold,
// redirects in every state, PC wrap and reset during DISCARD.
`default_nettype none

module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        busywait_drv;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        if_busywait;

  int checks;
  int errors;

  instruction_fetch_if imem ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00000000: mem_word = 32'h00310093;
      32'h00000004: mem_word = 32'h00208133;
      default:      mem_word = a ^ 32'hC0DE0000;
    endcase
  endfunction

  assign imem.readdata = mem_word(imem.addr);
  assign imem.busywait = busywait_drv;

  instruction_fetch #(
    .RESET_VECTOR(32'h00000000),
    .NOP_INSTR   (32'h00000013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .imem            (imem),
    .if_pc           (if_pc),
    .if_instruction  (if_instruction),
    .if_pc_plus4     (if_pc_plus4),
    .if_valid        (if_valid),
    .if_busywait     (if_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; ex_branch_taken = 1'b0;
    ex_branch_target = 32'd0; busywait_drv = 1'b0;
    tick(); tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_instruction !== 32'h00000013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", if_instruction); end
    checks++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h expected 0/0", if_pc, if_pc_plus4); end
    checks++; if (imem.read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", imem.read); end
    checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem.addr); end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    #1;
    checks++; if (imem.read !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL seq_req0: got read=%b addr=%h expected 1/0", imem.read, imem.addr); end
    tick();
    checks++; if (if_pc !== 32'h0 || if_instruction !== 32'h00310093 || if_pc_plus4 !== 32'h4 || if_valid !== 1'b1)
      begin errors++; $display("FAIL seq_first: got %h %h %h %b expected 0 00310093 4 1", if_pc, if_instruction, if_pc_plus4, if_valid); end
    tick();
    checks++; if (if_pc !== 32'h4 || if_instruction !== 32'h00208133 || if_pc_plus4 !== 32'h8 || if_valid !== 1'b1)
      begin errors++; $display("FAIL seq_second: got %h %h %h %b expected 4 00208133 8 1", if_pc, if_instruction, if_pc_plus4, if_valid); end
    checks++; if (imem.addr !== 32'h8) begin errors++; $display("FAIL seq_addr: got %h expected 8", imem.addr); end
  endtask

  task automatic test_busywait();
    busywait_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      #1;
      checks++; if (if_busywait !== 1'b1) begin errors++; $display("FAIL bw_flag[%0d]: got %b expected 1", i, if_busywait); end
      tick();
      checks++; if (if_pc !== 32'h4 || if_instruction !== 32'h00208133 || imem.addr !== 32'h8)
        begin errors++; $display("FAIL bw_hold[%0d]: got pc=%h instr=%h addr=%h expected 4 00208133 8", i, if_pc, if_instruction, imem.addr); end
    end
    stall = 1'b0; busywait_drv = 1'b0;
    #1;
    checks++; if (if_busywait !== 1'b0) begin errors++; $display("FAIL bw_release: got %b expected 0", if_busywait); end
    tick();
    checks++; if (if_pc !== 32'h8 || if_instruction !== 32'hC0DE0008 || if_pc_plus4 !== 32'hC)
      begin errors++; $display("FAIL bw_load: got %h %h %h expected 8 c0de0008 c", if_pc, if_instruction, if_pc_plus4); end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    tick();
    checks++; if (imem.read !== 1'b0 || if_busywait !== 1'b0) begin errors++; $display("FAIL hold_read: got read=%b bw=%b expected 0/0", imem.read, if_busywait); end
    tick();
    checks++; if (if_pc !== 32'h8 || imem.read !== 1'b0 || imem.addr !== 32'hC)
      begin errors++; $display("FAIL hold_keep: got pc=%h read=%b addr=%h expected 8 0 c", if_pc, imem.read, imem.addr); end
    stall = 1'b0;
    tick();
    checks++; if (if_pc !== 32'hC || if_instruction !== 32'hC0DE000C || if_pc_plus4 !== 32'h10 || if_valid !== 1'b1)
      begin errors++; $display("FAIL hold_release: got %h %h %h %b expected c c0de000c 10 1", if_pc, if_instruction, if_pc_plus4, if_valid); end
    checks++; if (imem.addr !== 32'h10 || imem.read !== 1'b1) begin errors++; $display("FAIL hold_nextpc: got %h/%b expected 10/1", imem.addr, imem.read); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
    tick();
    ex_branch_taken = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instruction !== 32'h00000013 || if_pc !== 32'h0)
      begin errors++; $display("FAIL redir_flush: got %b %h %h expected 0 00000013 0", if_valid, if_instruction, if_pc); end
    checks++; if (imem.addr !== 32'h40 || imem.read !== 1'b1) begin errors++; $display("FAIL redir_addr: got %h/%b expected 40/1", imem.addr, imem.read); end
    tick();
    checks++; if (if_pc !== 32'h40 || if_instruction !== 32'hC0DE0040 || if_valid !== 1'b1)
      begin errors++; $display("FAIL redir_fetch: got %h %h %b expected 40 c0de0040 1", if_pc, if_instruction, if_valid); end
    // redirect out of HOLD drops the buffered word at 0x44
    stall = 1'b1;
    tick();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h60;
    tick();
    ex_branch_taken = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem.addr !== 32'h60 || imem.read !== 1'b1)
      begin errors++; $display("FAIL redir_hold: got valid=%b addr=%h read=%b expected 0 60 1", if_valid, imem.addr, imem.read); end
    tick();
    checks++; if (if_pc !== 32'h60 || if_instruction !== 32'hC0DE0060)
      begin errors++; $display("FAIL redir_hold_fetch: got %h %h expected 60 c0de0060", if_pc, if_instruction); end
  endtask

  task automatic test_discard();
    busywait_drv = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h83;
    tick();
    ex_branch_taken = 1'b0;
    checks++; if (imem.read !== 1'b0 || if_busywait !== 1'b1 || imem.addr !== 32'h80 || if_valid !== 1'b0)
      begin errors++; $display("FAIL disc_enter: got read=%b bw=%b addr=%h valid=%b expected 0 1 80 0", imem.read, if_busywait, imem.addr, if_valid); end
    tick();
    checks++; if (if_busywait !== 1'b1 || imem.read !== 1'b0) begin errors++; $display("FAIL disc_wait: got bw=%b read=%b expected 1 0", if_busywait, imem.read); end
    busywait_drv = 1'b0;
    tick();
    checks++; if (imem.read !== 1'b1 || imem.addr !== 32'h80 || if_valid !== 1'b0)
      begin errors++; $display("FAIL disc_exit: got read=%b addr=%h valid=%b expected 1 80 0", imem.read, imem.addr, if_valid); end
    tick();
    checks++; if (if_pc !== 32'h80 || if_instruction !== 32'hC0DE0080 || if_pc_plus4 !== 32'h84)
      begin errors++; $display("FAIL disc_fetch: got %h %h %h expected 80 c0de0080 84", if_pc, if_instruction, if_pc_plus4); end
    // second redirect while draining only retargets the PC
    busywait_drv = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h100;
    tick();
    ex_branch_target = 32'h201;
    tick();
    ex_branch_taken = 1'b0;
    checks++; if (imem.addr !== 32'h200 || if_busywait !== 1'b1 || if_valid !== 1'b0)
      begin errors++; $display("FAIL disc_retarget: got addr=%h bw=%b valid=%b expected 200 1 0", imem.addr, if_busywait, if_valid); end
    busywait_drv = 1'b0;
    tick();
    checks++; if (imem.read !== 1'b1 || imem.addr !== 32'h200) begin errors++; $display("FAIL disc_retarget_exit: got %b/%h expected 1/200", imem.read, imem.addr); end
  endtask

  task automatic test_wrap_and_reset();
    ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFFFFFC;
    tick();
    ex_branch_taken = 1'b0;
    checks++; if (imem.addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem.addr); end
    tick();
    checks++; if (if_pc !== 32'hFFFFFFFC || if_pc_plus4 !== 32'h0 || if_instruction !== 32'h3F21FFFC || if_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_ifid: got %h %h %h %b expected fffffffc 0 3f21fffc 1", if_pc, if_pc_plus4, if_instruction, if_valid); end
    checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 0", imem.addr); end
    busywait_drv = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
    tick();
    ex_branch_taken = 1'b0; rst = 1'b1;
    #1;
    checks++; if (imem.read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", imem.read); end
    tick();
    rst = 1'b0; busywait_drv = 1'b0;
    #1;
    checks++; if (imem.read !== 1'b1 || imem.addr !== 32'h0 || if_valid !== 1'b0 || if_instruction !== 32'h00000013)
      begin errors++; $display("FAIL rst_disc: got read=%b addr=%h valid=%b instr=%h expected 1 0 0 00000013", imem.read, imem.addr, if_valid, if_instruction); end
    tick();
    checks++; if (if_pc !== 32'h0 || if_instruction !== 32'h00310093 || if_valid !== 1'b1)
      begin errors++; $display("FAIL rst_refetch: got %h %h %b expected 0 00310093 1", if_pc, if_instruction, if_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_busywait();
    test_stall_hold();
    test_redirect();
    test_discard();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush/reset.
REQ-003 Port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port RST  input  1  reset, synchronous, active-high.
REQ-005 Port STALL  input  1  hazard hold from downstream; IF/ID and PC hold.
REQ-006 Port EX_BRANCH_TAKEN  input  1  redirect request (branch/jump resolved).
REQ-007 Port EX_BRANCH_TARGET  input  32  redirect address.
REQ-008 Port IMEM_ADDR  output  32  instruction memory address (= PC).
REQ-009 Port IMEM_READ  output  1  instruction memory read request.
REQ-010 Port IMEM_READDATA  input  32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
REQ-011 Port IMEM_BUSYWAIT  input  1  memory not ready.
REQ-012 Port IF_PC  output  32  IF/ID register: PC of held instruction.
REQ-013 Port IF_INSTRUCTION  output  32  IF/ID register: instruction word.
REQ-014 Port IF_PC_PLUS4  output  32  IF/ID register: IF_PC+4.
REQ-015 Port IF_VALID  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 Port IF_BUSYWAIT  output  1  fetch unable to deliver this cycle; pipeline must freeze.

Function
REQ-017 The block SHALL hold a 32-bit PC register and a 3-state FSM: FETCH, HOLD, DISCARD.
REQ-018 FETCH: IMEM_READ=1, IMEM_ADDR=PC; IF_BUSYWAIT=IMEM_BUSYWAIT.
REQ-019 FETCH, BUSYWAIT=0, no redirect, STALL=0: IF/ID <= {PC, READDATA, PC+4, valid=1}; PC <= PC+4; stay FETCH (1 instruction/cycle with zero-wait memory).
REQ-020 FETCH, BUSYWAIT=0, no redirect, STALL=1: READDATA captured in internal buffer; IF/ID and PC hold; go HOLD.
REQ-021 HOLD: IMEM_READ=0, IF_BUSYWAIT=0; on STALL=0 load IF/ID from buffer, PC <= PC+4, go FETCH.
REQ-022 Redirect (EX_BRANCH_TAKEN=1) SHALL take priority over STALL and fetch completion in every state.
REQ-023 Redirect in FETCH with BUSYWAIT=0, or in HOLD: PC <= target; IF/ID <= {0, NOP_INSTR, 0, valid=0}; buffer dropped; go FETCH.
REQ-024 Redirect in FETCH with BUSYWAIT=1: PC <= target; IF/ID flushed as REQ-023; go DISCARD.
REQ-025 DISCARD: IMEM_READ=0, IF_BUSYWAIT=1; on BUSYWAIT=0 returned data dropped, go FETCH; a further redirect in DISCARD updates PC only.
REQ-026 FETCH, BUSYWAIT=1, no redirect: PC, IF/ID, state hold regardless of STALL.
REQ-027 Redirect target bits [1:0] SHALL be forced to 0 when loaded into PC.
REQ-028 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), no flag.
REQ-029 IF_PC_PLUS4 SHALL always equal IF_PC+4 when IF_VALID=1.

Reset
REQ-030 RST=1 at an edge SHALL set PC=RESET_VECTOR, state=FETCH, IF_PC=0, IF_INSTRUCTION=NOP_INSTR, IF_PC_PLUS4=0, IF_VALID=0, buffer cleared, overriding all other inputs.
REQ-031 Reset during DISCARD or HOLD SHALL abandon the pending/buffered word; first post-reset request is to RESET_VECTOR.
REQ-032 While RST=1, IMEM_READ SHALL be 0.

Verification
REQ-033 Zero-wait memory returning 32'h00310093, 32'h00208133 at 0x0, 0x4; release RST -> IF_PC 0x0 then 0x4 on consecutive edges, IF_PC_PLUS4 0x4 then 0x8, IF_VALID=1.
REQ-034 BUSYWAIT high 3 cycles at PC=0x8 -> IF_BUSYWAIT=1 for 3 cycles, IF/ID unchanged, loads 0x8 on 4th edge.
REQ-035 STALL=1 for 2 cycles as word at 0xC returns -> HOLD entered, IMEM_READ=0, IF/ID held; STALL drop -> IF_PC=0xC, PC=0x10.
REQ-036 Redirect to 0x40 with STALL=1 -> IF_VALID=0, IF_INSTRUCTION=32'h00000013, next fetch IMEM_ADDR=0x40.
REQ-037 Redirect to 0x83 while BUSYWAIT=1 -> DISCARD, stale word dropped, next fetch at 0x80.
REQ-038 PC=0xFFFFFFFC fetched -> IF_PC_PLUS4=0x0, next IMEM_ADDR=0x0; RST asserted in DISCARD -> next request 0x0.
